// File: rtl/bn_pkg.sv
// Shared types and constants for the bn_pack batch-norm packer.
package bn_pkg;

    typedef enum logic [1:0] {
        StFill,
        StIssue,
        StWaitBusy,
        StWaitDone
    } bn_state_e;

    localparam int unsigned FracBits   = 4;
    localparam int unsigned RoundConst = 8;

endpackage

// File: rtl/bn_lane_sat.sv
// Per-lane scale shift, beta add and clamp to the unsigned packed lane width.
// Build option BN_PACK_ROUND_EN selects round-half-up instead of floor on the shift.
module bn_lane_sat
    import bn_pkg::*;
#(
    parameter int unsigned PW     = 16,
    parameter int unsigned DW_OUT = 4
) (
    input  logic signed [PW-1:0] prod_i,
    input  logic signed [7:0]    beta_i,
    output logic [DW_OUT-1:0]    lane_o
);

    // Two guard bits keep the rounded, offset sum from overflowing before the clamp.
    localparam int unsigned   SW     = PW + 2;
    localparam logic [SW-1:0] MaxOut = SW'((1 << DW_OUT) - 1);

`ifdef BN_PACK_ROUND_EN
    localparam logic RoundEn = 1'b1;
`else
    localparam logic RoundEn = 1'b0;
`endif

    logic signed [SW-1:0] prod_ext;
    logic signed [SW-1:0] shifted;
    logic signed [SW-1:0] sum;

    always_comb begin
        prod_ext = {{2{prod_i[PW-1]}}, prod_i};
        if (RoundEn) begin
            prod_ext = prod_ext + SW'(RoundConst);
        end
        shifted = prod_ext >>> FracBits;
        sum     = shifted + {{(SW-8){beta_i[7]}}, beta_i};
        if (sum[SW-1]) begin
            lane_o = '0;
        end else if ($unsigned(sum) > MaxOut) begin
            lane_o = '1;
        end else begin
            lane_o = sum[DW_OUT-1:0];
        end
    end

endmodule

// File: rtl/bn_pack.sv
// Batch-norm packer: scales samples into LANES unsigned lanes and hands each full
// vector to the MVM with a start pulse. Build option BN_PACK_ROUND_EN (see bn_lane_sat).
module bn_pack
    import bn_pkg::*;
#(
    parameter int unsigned LANES  = 4,
    parameter int unsigned DW_IN  = 8,
    parameter int unsigned DW_OUT = 4
) (
    input  logic                      i_clk_bn,
    input  logic                      i_rst_bn,
    input  logic                      i_valid_bn,
    output logic                      o_ready_bn,
    input  logic signed [DW_IN-1:0]   i_data_bn,
    input  logic [LANES*8-1:0]        i_gamma_bn,
    input  logic [LANES*8-1:0]        i_beta_bn,
    input  logic                      i_ismvm,
    output logic                      o_start_mvm,
    output logic [LANES*DW_OUT-1:0]   o_x_bn,
    output logic [15:0]               o_vec_cnt_bn
);

    localparam int unsigned CW = $clog2(LANES + 1);
    localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned PW = DW_IN + 8;

    bn_state_e               state_q, state_d;
    logic [CW-1:0]           acc_cnt_q, acc_cnt_d;
    logic [CW-1:0]           wr_cnt_q, wr_cnt_d;
    logic                    s0_vld_q, s0_vld_d;
    logic signed [DW_IN-1:0] s0_x_q, s0_x_d;
    logic [LW-1:0]           s0_lane_q, s0_lane_d;
    logic                    s1_vld_q, s1_vld_d;
    logic signed [PW-1:0]    s1_prod_q, s1_prod_d;
    logic [LW-1:0]           s1_lane_q, s1_lane_d;
    logic [LANES*DW_OUT-1:0] x_q, x_d;
    logic                    start_q, start_d;
    logic [15:0]             vec_cnt_q, vec_cnt_d;

    logic                    accept;
    logic signed [7:0]       gamma_sel;
    logic signed [7:0]       beta_sel;
    logic [DW_OUT-1:0]       lane_res;

    assign o_ready_bn   = (state_q == StFill) && (acc_cnt_q < CW'(LANES));
    assign accept       = i_valid_bn && o_ready_bn;
    assign gamma_sel    = i_gamma_bn[s0_lane_q*8 +: 8];
    assign beta_sel     = i_beta_bn[s1_lane_q*8 +: 8];
    assign o_start_mvm  = start_q;
    assign o_x_bn       = x_q;
    assign o_vec_cnt_bn = vec_cnt_q;

    bn_lane_sat #(
        .PW     (PW),
        .DW_OUT (DW_OUT)
    ) u_lane_sat (
        .prod_i (s1_prod_q),
        .beta_i (beta_sel),
        .lane_o (lane_res)
    );

    // Stage 0 registers the sample, stage 1 the gamma product, stage 2 writes the lane.
    always_comb begin
        s0_vld_d  = accept;
        s0_x_d    = accept ? i_data_bn : s0_x_q;
        s0_lane_d = accept ? acc_cnt_q[LW-1:0] : s0_lane_q;
        s1_vld_d  = s0_vld_q;
        s1_prod_d = s0_vld_q ? s0_x_q * gamma_sel : s1_prod_q;
        s1_lane_d = s0_vld_q ? s0_lane_q : s1_lane_q;
        x_d       = x_q;
        if (s1_vld_q) begin
            x_d[s1_lane_q*DW_OUT +: DW_OUT] = lane_res;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_cnt_d = acc_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        start_d   = 1'b0;
        vec_cnt_d = vec_cnt_q;
        unique case (state_q)
            StFill: begin
                if (accept) begin
                    acc_cnt_d = acc_cnt_q + 1'b1;
                end
                if (s1_vld_q) begin
                    wr_cnt_d = wr_cnt_q + 1'b1;
                    if (wr_cnt_q == CW'(LANES - 1)) begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                if (!i_ismvm) begin
                    start_d   = 1'b1;
                    vec_cnt_d = vec_cnt_q + 16'd1;
                    state_d   = StWaitBusy;
                end
            end
            StWaitBusy: begin
                if (i_ismvm) begin
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (!i_ismvm) begin
                    state_d   = StFill;
                    acc_cnt_d = '0;
                    wr_cnt_d  = '0;
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge i_clk_bn or negedge i_rst_bn) begin
        if (!i_rst_bn) begin
            state_q   <= StFill;
            acc_cnt_q <= '0;
            wr_cnt_q  <= '0;
            s0_vld_q  <= 1'b0;
            s0_x_q    <= '0;
            s0_lane_q <= '0;
            s1_vld_q  <= 1'b0;
            s1_prod_q <= '0;
            s1_lane_q <= '0;
            x_q       <= '0;
            start_q   <= 1'b0;
            vec_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_cnt_q <= acc_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            s0_vld_q  <= s0_vld_d;
            s0_x_q    <= s0_x_d;
            s0_lane_q <= s0_lane_d;
            s1_vld_q  <= s1_vld_d;
            s1_prod_q <= s1_prod_d;
            s1_lane_q <= s1_lane_d;
            x_q       <= x_d;
            start_q   <= start_d;
            vec_cnt_q <= vec_cnt_d;
        end
    end

endmodule

// File: tb/tb_bn_pack.sv
// Directed self-checking bench for bn_pack with hand-computed lane vectors.
`timescale 1ns/1ps
module tb_bn_pack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic        ready;
    logic [7:0]  data;
    logic [31:0] gamma;
    logic [31:0] beta;
    logic        ismvm;
    logic        start;
    logic [15:0] x;
    logic [15:0] cnt;

    int n_vec = 0;
    int n_err = 0;

`ifdef BN_PACK_ROUND_EN
    localparam logic [15:0] ExpRound = 16'h9112;
`else
    localparam logic [15:0] ExpRound = 16'h9001;
`endif

    always #5 clk = ~clk;

    bn_pack dut (
        .i_clk_bn     (clk),
        .i_rst_bn     (rst_n),
        .i_valid_bn   (valid),
        .o_ready_bn   (ready),
        .i_data_bn    (data),
        .i_gamma_bn   (gamma),
        .i_beta_bn    (beta),
        .i_ismvm      (ismvm),
        .o_start_mvm  (start),
        .o_x_bn       (x),
        .o_vec_cnt_bn (cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        while (!ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk("push_ready_timeout", 32'(ready), 32'd1);
        valid = 1'b1;
        data  = d;
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic wait_start(input string tag, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!start && lat < 60);
        chk({tag, "_pulse"}, 32'(start), 32'd1);
    endtask

    // Acts as the MVM: goes busy after the pulse, then releases.
    task automatic mvm_ack(input string tag, input int busy, input logic [15:0] exp_x);
        ismvm = 1'b1;
        @(negedge clk);
        chk({tag, "_pulse_width"}, 32'(start), 32'd0);
        chk({tag, "_ready_busy"}, 32'(ready), 32'd0);
        for (int i = 0; i < busy; i++) @(negedge clk);
        chk({tag, "_x_hold"}, 32'(x), 32'(exp_x));
        ismvm = 1'b0;
        @(negedge clk);
        chk({tag, "_ready_refill"}, 32'(ready), 32'd1);
        chk({tag, "_no_repulse"}, 32'(start), 32'd0);
    endtask

    task automatic finish_vec(input string tag, input logic [15:0] exp_x,
                              input logic [15:0] exp_cnt);
        int lat;
        wait_start(tag, lat);
        chk({tag, "_latency"}, 32'(lat), 32'd4);
        chk({tag, "_x"}, 32'(x), 32'(exp_x));
        chk({tag, "_cnt"}, 32'(cnt), 32'(exp_cnt));
        mvm_ack(tag, 2, exp_x);
    endtask

    task automatic run_vec(input string tag, input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input logic [7:0] d3,
                           input logic [15:0] exp_x, input logic [15:0] exp_cnt);
        push(d0);
        push(d1);
        push(d2);
        push(d3);
        finish_vec(tag, exp_x, exp_cnt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst_n = 1'b0;
        valid = 1'b0;
        data  = 8'h00;
        gamma = 32'h1010_1010;
        beta  = 32'h0000_0000;
        ismvm = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_x", 32'(x), 32'd0);
        chk("rst_cnt", 32'(cnt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);

        run_vec("basic", 8'd5, 8'd6, 8'd7, 8'd3, 16'h3765, 16'd1);
        run_vec("sat", 8'hFD, 8'h7F, 8'h00, 8'h0F, 16'hF0F0, 16'd2);

        gamma = 32'h0808_0808;
        beta  = 32'hFF00_0200;
        run_vec("round", 8'h03, 8'hFD, 8'h01, 8'h14, ExpRound, 16'd3);

        gamma = 32'hF030_2010;
        beta  = 32'h0AFE_0001;
        run_vec("lanes", 8'd2, 8'd2, 8'd2, 8'd2, 16'h8443, 16'd4);

        // Gamma change lands on sample 2's product stage, beta change on sample 2's write.
        gamma = 32'h1010_1010;
        beta  = 32'h0000_0000;
        push(8'd4);
        push(8'd4);
        gamma = 32'h2020_2020;
        push(8'd4);
        beta  = 32'h0101_0101;
        push(8'd4);
        finish_vec("midvec", 16'h9994, 16'd5);

        gamma = 32'h1010_1010;
        beta  = 32'h0000_0000;
        ismvm = 1'b1;
        push(8'd1);
        push(8'd2);
        push(8'd3);
        push(8'd4);
        valid = 1'b1;
        data  = 8'h7F;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("hold_no_pulse", 32'(start), 32'd0);
            chk("hold_not_ready", 32'(ready), 32'd0);
        end
        chk("hold_x", 32'(x), 32'h4321);
        valid = 1'b0;
        ismvm = 1'b0;
        wait_start("hold", lat);
        chk("hold_latency", 32'(lat), 32'd1);
        chk("hold_cnt", 32'(cnt), 32'd6);
        mvm_ack("hold", 3, 16'h4321);
        run_vec("post_ignore", 8'd1, 8'd1, 8'd2, 8'd2, 16'h2211, 16'd7);

        push(8'd9);
        push(8'd9);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_x", 32'(x), 32'd0);
        chk("midrst_start", 32'(start), 32'd0);
        chk("midrst_cnt", 32'(cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("midrst_no_pulse", 32'(start), 32'd0);
        end
        chk("midrst_no_stale", 32'(x), 32'd0);
        run_vec("after_rst", 8'd1, 8'd1, 8'd1, 8'd1, 16'h1111, 16'd1);

        // Jump the issue counter to just below the wrap point.
        @(negedge clk);
        force dut.vec_cnt_q = 16'hFFFE;
        repeat (2) @(negedge clk);
        release dut.vec_cnt_q;
        @(negedge clk);
        chk("preload_cnt", 32'(cnt), 32'hFFFE);
        run_vec("wrap_a", 8'd2, 8'd3, 8'd4, 8'd5, 16'h5432, 16'hFFFF);
        run_vec("wrap_b", 8'd6, 8'd7, 8'd8, 8'd9, 16'h9876, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
